// File: rtl/game_pkg.sv
// Shared game definitions: obstacle select codes, sequencer state encoding
// and counter widths used by the sequencer and the obstacle modules.
package game_pkg;

    localparam int N_OBS     = 4;
    localparam int GAP_CNT_W = 27;
    localparam int WD_CNT_W  = 30;

    localparam logic [N_OBS-1:0] OBS_NONE = 4'b0000;
    localparam logic [N_OBS-1:0] OBS_0    = 4'b0001;
    localparam logic [N_OBS-1:0] OBS_1    = 4'b0010;
    localparam logic [N_OBS-1:0] OBS_2    = 4'b0100;
    localparam logic [N_OBS-1:0] OBS_3    = 4'b1000;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_SELECT = 3'd1,
        ST_ARM    = 3'd2,
        ST_RUN    = 3'd3,
        ST_GAP    = 3'd4
    } seq_state_e;

    // One-hot select code for an obstacle index.
    function automatic logic [N_OBS-1:0] obs_code(input logic [1:0] idx);
        logic [N_OBS-1:0] code;
        case (idx)
            2'd0:    code = OBS_0;
            2'd1:    code = OBS_1;
            2'd2:    code = OBS_2;
            default: code = OBS_3;
        endcase
        return code;
    endfunction

    // Random pick that never repeats the previous obstacle.
    function automatic logic [1:0] pick_idx(input logic [1:0] raw, input logic [1:0] last);
        return (raw == last) ? raw + 2'd1 : raw;
    endfunction

endpackage

// File: rtl/lfsr8.sv
// Free-running 8-bit Fibonacci LFSR, polynomial x^8+x^6+x^5+x^4+1.
module lfsr8 (
    input  logic       clk,
    input  logic       rst,
    input  logic [7:0] seed,
    output logic [7:0] q
);

    logic [7:0] q_q;
    logic [7:0] q_d;

    // Shift toward the MSB, feeding the tap XOR back into bit 0.
    always_comb begin
        q_d = {q_q[6:0], q_q[7] ^ q_q[5] ^ q_q[4] ^ q_q[3]};
    end

    // State register; the seed must be nonzero or the sequence locks up.
    always_ff @(posedge clk) begin
        if (rst) begin
            q_q <= seed;
        end else begin
            q_q <= q_d;
        end
    end

    assign q = q_q;

endmodule

// File: rtl/obstacle_sequencer.sv
// Obstacle sequencer: picks a random obstacle (never the same one twice in a
// row), launches it, waits for its done pulse or a watchdog expiry, pauses for
// a gap, and repeats until the menu opens or gameplay stops.
//
//   state     | meaning
//   ----------+--------------------------------------------------------
//   ST_IDLE   | no sequence; waiting for start_game while game is on
//   ST_SELECT | pick next obstacle from the LFSR, load select outputs
//   ST_ARM    | select stable; emit the one-cycle start_pulse
//   ST_RUN    | obstacle running; watch its done bit and the watchdog
//   ST_GAP    | idle pause between obstacles, selection held
module obstacle_sequencer #(
    parameter int unsigned GAP_CYCLES      = 65000000,
    parameter int unsigned WATCHDOG_CYCLES = 975000000,
    parameter logic [7:0]  LFSR_SEED       = 8'hA5
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       game_on,
    input  logic       menu_on,
    input  logic       start_game,
    input  logic [3:0] obstacle_done,
    output logic [3:0] selected,
    output logic       play_selected,
    output logic       start_pulse,
    output logic [7:0] round_count,
    output logic       busy,
    output logic       timeout_flag
);

    import game_pkg::*;

    localparam int unsigned GAP_MAX = 32'd1 << GAP_CNT_W;
    localparam int unsigned WD_MAX  = 32'd1 << WD_CNT_W;

    if (GAP_CYCLES < 1 || GAP_CYCLES > GAP_MAX) begin : g_bad_gap
        $error("GAP_CYCLES does not fit the 27-bit gap counter");
    end
    if (WATCHDOG_CYCLES < 1 || WATCHDOG_CYCLES > WD_MAX) begin : g_bad_wd
        $error("WATCHDOG_CYCLES does not fit the 30-bit watchdog counter");
    end
    if (LFSR_SEED == 8'h00) begin : g_bad_seed
        $error("LFSR_SEED must be nonzero");
    end

    localparam logic [GAP_CNT_W-1:0] GAP_LAST = GAP_CNT_W'(GAP_CYCLES - 1);
    localparam logic [WD_CNT_W-1:0]  WD_LAST  = WD_CNT_W'(WATCHDOG_CYCLES - 1);

    seq_state_e           state_q, state_d;
    logic [N_OBS-1:0]     selected_q, selected_d;
    logic                 play_q, play_d;
    logic                 start_pulse_q, start_pulse_d;
    logic [7:0]           round_q, round_d;
    logic                 busy_q, busy_d;
    logic                 timeout_q, timeout_d;
    logic [1:0]           last_idx_q, last_idx_d;
    logic [GAP_CNT_W-1:0] gap_q, gap_d;
    logic [WD_CNT_W-1:0]  wd_q, wd_d;

    logic [7:0] lfsr_val;
    logic       unused_lfsr_bits;
    logic [1:0] pick;
    logic       done_hit;
    logic       abort;

    lfsr8 u_lfsr (
        .clk  (clk),
        .rst  (rst),
        .seed (LFSR_SEED),
        .q    (lfsr_val)
    );

    // Only the low two bits choose the obstacle; the rest just shift.
    assign unused_lfsr_bits = ^lfsr_val[7:2];

    // Next-state and next-output logic; abort outranks every other event.
    always_comb begin
        state_d       = state_q;
        selected_d    = selected_q;
        play_d        = play_q;
        start_pulse_d = 1'b0;
        round_d       = round_q;
        timeout_d     = timeout_q;
        last_idx_d    = last_idx_q;
        gap_d         = gap_q;
        wd_d          = wd_q;
        pick          = pick_idx(lfsr_val[1:0], last_idx_q);
        done_hit      = obstacle_done[last_idx_q];
        abort         = menu_on || !game_on;

        if (state_q != ST_IDLE && abort) begin
            state_d    = ST_IDLE;
            selected_d = OBS_NONE;
            play_d     = 1'b0;
            gap_d      = '0;
            wd_d       = '0;
        end else begin
            unique case (state_q)
                ST_IDLE: begin
                    selected_d = OBS_NONE;
                    play_d     = 1'b0;
                    if (start_game && game_on && !menu_on) begin
                        state_d   = ST_SELECT;
                        round_d   = 8'd0;
                        timeout_d = 1'b0;
                    end
                end
                ST_SELECT: begin
                    selected_d = obs_code(pick);
                    play_d     = 1'b1;
                    last_idx_d = pick;
                    state_d    = ST_ARM;
                end
                ST_ARM: begin
                    start_pulse_d = 1'b1;
                    wd_d          = '0;
                    state_d       = ST_RUN;
                end
                ST_RUN: begin
                    // A done on the watchdog's last cycle still counts as a completion.
                    if (done_hit) begin
                        if (round_q != 8'hFF) begin
                            round_d = round_q + 8'd1;
                        end
                        play_d  = 1'b0;
                        gap_d   = '0;
                        state_d = ST_GAP;
                    end else if (wd_q == WD_LAST) begin
                        timeout_d = 1'b1;
                        play_d    = 1'b0;
                        gap_d     = '0;
                        state_d   = ST_GAP;
                    end else begin
                        wd_d = wd_q + WD_CNT_W'(1);
                    end
                end
                ST_GAP: begin
                    if (gap_q == GAP_LAST) begin
                        state_d = ST_SELECT;
                    end else begin
                        gap_d = gap_q + GAP_CNT_W'(1);
                    end
                end
                default: begin
                    state_d = ST_IDLE;
                end
            endcase
        end

        busy_d = (state_d != ST_IDLE);
    end

    // State and registered outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q       <= ST_IDLE;
            selected_q    <= OBS_NONE;
            play_q        <= 1'b0;
            start_pulse_q <= 1'b0;
            round_q       <= 8'd0;
            busy_q        <= 1'b0;
            timeout_q     <= 1'b0;
            last_idx_q    <= 2'd3;
            gap_q         <= '0;
            wd_q          <= '0;
        end else begin
            state_q       <= state_d;
            selected_q    <= selected_d;
            play_q        <= play_d;
            start_pulse_q <= start_pulse_d;
            round_q       <= round_d;
            busy_q        <= busy_d;
            timeout_q     <= timeout_d;
            last_idx_q    <= last_idx_d;
            gap_q         <= gap_d;
            wd_q          <= wd_d;
        end
    end

    assign selected      = selected_q;
    assign play_selected = play_q;
    assign start_pulse   = start_pulse_q;
    assign round_count   = round_q;
    assign busy          = busy_q;
    assign timeout_flag  = timeout_q;

endmodule
